// File: rtl/midori_sbox_seq_pkg.sv
// Shared types, constants and index helpers for the Midori masked S-box sequencer.
package midori_sbox_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NIBBLES    = 16;
  localparam int R_PER_SBOX = 96;
  localparam int NB_W       = 8;

  // Neighbour of nibble n is (n+1) mod 16; the 4-bit add wraps by itself.
  function automatic logic [3:0] nb_idx(input logic [3:0] n);
    return n + 4'd1;
  endfunction

  // Absolute nibble position of slot k within batch bidx.
  function automatic logic [3:0] batch_nib(input int bidx, input int nsbox, input int k);
    return 4'(bidx * nsbox + k);
  endfunction

endpackage

// File: rtl/midori_sbox_batch_mux.sv
// Selects the nibbles of batch b from the three input shares, plus shares 1 and 2
// of each nibble's right-hand neighbour.
module midori_sbox_batch_mux
  import midori_sbox_seq_pkg::*;
#(
  parameter int NSBOX = 4,
  parameter int BW    = 2
) (
  input  logic [63:0]            s1,
  input  logic [63:0]            s2,
  input  logic [63:0]            s3,
  input  logic [BW-1:0]          b,
  output logic [4*NSBOX-1:0]     n1,
  output logic [4*NSBOX-1:0]     n2,
  output logic [4*NSBOX-1:0]     n3,
  output logic [NB_W*NSBOX-1:0]  nb
);

  logic [3:0] pos [NSBOX];
  logic [3:0] npos [NSBOX];

  always_comb begin
    for (int k = 0; k < NSBOX; k++) begin
      pos[k]  = batch_nib(int'(b), NSBOX, k);
      npos[k] = nb_idx(pos[k]);
    end
  end

  always_comb begin
    n1 = '0;
    n2 = '0;
    n3 = '0;
    nb = '0;
    for (int k = 0; k < NSBOX; k++) begin
      n1[4*k +: 4]       = s1[{pos[k], 2'b00} +: 4];
      n2[4*k +: 4]       = s2[{pos[k], 2'b00} +: 4];
      n3[4*k +: 4]       = s3[{pos[k], 2'b00} +: 4];
      nb[NB_W*k +: NB_W] = {s2[{npos[k], 2'b00} +: 4], s1[{npos[k], 2'b00} +: 4]};
    end
  end

endmodule

// File: rtl/midori_sbox_seq.sv
// Feeds a 3-share 64-bit Midori state through NSBOX external masked S-boxes in
// 16/NSBOX batches and gathers the output shares into a 3-share result.
module midori_sbox_seq
  import midori_sbox_seq_pkg::*;
#(
  parameter int NSBOX    = 4,
  parameter int SBOX_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [63:0]                 in_s1,
  input  logic [63:0]                 in_s2,
  input  logic [63:0]                 in_s3,
  input  logic                        rnd_valid,
  output logic                        rnd_ready,
  input  logic [R_PER_SBOX*NSBOX-1:0] rnd,
  output logic [4*NSBOX-1:0]          sb_in1,
  output logic [4*NSBOX-1:0]          sb_in2,
  output logic [4*NSBOX-1:0]          sb_in3,
  output logic [NB_W*NSBOX-1:0]       sb_nb,
  output logic [R_PER_SBOX*NSBOX-1:0] sb_r,
  input  logic [4*NSBOX-1:0]          sb_out1,
  input  logic [4*NSBOX-1:0]          sb_out2,
  input  logic [4*NSBOX-1:0]          sb_out3,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [63:0]                 out_s1,
  output logic [63:0]                 out_s2,
  output logic [63:0]                 out_s3,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  localparam int NBATCH = NIBBLES / NSBOX;
  localparam int BW     = (NBATCH > 1) ? $clog2(NBATCH) : 1;
  localparam int DEPTH  = SBOX_LAT + 1;
  localparam logic [BW-1:0] LAST_B = BW'(NBATCH - 1);

  state_e          state;
  logic [63:0]     in_r1, in_r2, in_r3;
  logic [63:0]     res1, res2, res3;
  logic [BW-1:0]   b;
  logic [DEPTH-1:0] flg_v;
  logic [BW-1:0]   flg_b [DEPTH];

  logic [4*NSBOX-1:0]    mux_n1, mux_n2, mux_n3;
  logic [NB_W*NSBOX-1:0] mux_nb;
  logic                  issue;

  // All handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid may not depend on ready, and ready is a pure function of state.
  assign in_ready  = (state == IDLE);
  assign rnd_ready = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign issue     = (state == ISSUE) && rnd_valid;
  assign out_s1    = res1;
  assign out_s2    = res2;
  assign out_s3    = res3;

  midori_sbox_batch_mux #(
    .NSBOX (NSBOX),
    .BW    (BW)
  ) u_mux (
    .s1 (in_r1),
    .s2 (in_r2),
    .s3 (in_r3),
    .b  (b),
    .n1 (mux_n1),
    .n2 (mux_n2),
    .n3 (mux_n3),
    .nb (mux_nb)
  );

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      in_r1     <= '0;
      in_r2     <= '0;
      in_r3     <= '0;
      b         <= '0;
      sb_in1    <= '0;
      sb_in2    <= '0;
      sb_in3    <= '0;
      sb_nb     <= '0;
      sb_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_r1 <= in_s1;
            in_r2 <= in_s2;
            in_r3 <= in_s3;
            b     <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Without a fresh word nothing is issued and the S-box inputs hold.
          if (rnd_valid) begin
            sb_in1 <= mux_n1;
            sb_in2 <= mux_n2;
            sb_in3 <= mux_n3;
            sb_nb  <= mux_nb;
            sb_r   <= rnd;
            b      <= b + BW'(1);
            if (b == LAST_B) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (flg_v == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flag pipeline tracks which batch the S-box outputs belong to; results land
  // in separate registers so later batches still see the original neighbours.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      flg_v <= '0;
      for (int i = 0; i < DEPTH; i++) flg_b[i] <= '0;
      res1 <= '0;
      res2 <= '0;
      res3 <= '0;
    end else begin
      flg_v[0] <= issue;
      flg_b[0] <= b;
      for (int i = 1; i < DEPTH; i++) begin
        flg_v[i] <= flg_v[i-1];
        flg_b[i] <= flg_b[i-1];
      end
      if (flg_v[DEPTH-1]) begin
        for (int k = 0; k < NSBOX; k++) begin
          res1[{batch_nib(int'(flg_b[DEPTH-1]), NSBOX, k), 2'b00} +: 4] <= sb_out1[4*k +: 4];
          res2[{batch_nib(int'(flg_b[DEPTH-1]), NSBOX, k), 2'b00} +: 4] <= sb_out2[4*k +: 4];
          res3[{batch_nib(int'(flg_b[DEPTH-1]), NSBOX, k), 2'b00} +: 4] <= sb_out3[4*k +: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_midori_sbox_seq.sv
// Bench for midori_sbox_seq with four behavioural masked Sb0 instances of one register stage.
module tb_midori_sbox_seq;

  localparam int NSBOX = 4;
  localparam int RW    = 96 * NSBOX;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_s1, in_s2, in_s3;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [RW-1:0]     rnd;
  logic [15:0]       sb_in1, sb_in2, sb_in3;
  logic [31:0]       sb_nb;
  logic [RW-1:0]     sb_r;
  logic [15:0]       sb_out1, sb_out2, sb_out3;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_s1, out_s2, out_s3;
  logic              busy;
  logic [1:0]        dbg_state;

  int                n_checks = 0;
  int                n_pass   = 0;
  int unsigned       word_ctr = 1;
  logic [63:0]       exp_q[$];

  midori_sbox_seq #(
    .NSBOX    (NSBOX),
    .SBOX_LAT (1)
  ) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s1     (in_s1),
    .in_s2     (in_s2),
    .in_s3     (in_s3),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd       (rnd),
    .sb_in1    (sb_in1),
    .sb_in2    (sb_in2),
    .sb_in3    (sb_in3),
    .sb_nb     (sb_nb),
    .sb_r      (sb_r),
    .sb_out1   (sb_out1),
    .sb_out2   (sb_out2),
    .sb_out3   (sb_out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s1    (out_s1),
    .out_s2    (out_s2),
    .out_s3    (out_s3),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- S-box stand-in ----------------
  function automatic logic [3:0] sb0(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'hA; 4'h2: return 4'hD; 4'h3: return 4'h3;
      4'h4: return 4'hE; 4'h5: return 4'hB; 4'h6: return 4'hF; 4'h7: return 4'h7;
      4'h8: return 4'h8; 4'h9: return 4'h9; 4'hA: return 4'h1; 4'hB: return 4'h5;
      4'hC: return 4'h0; 4'hD: return 4'h2; 4'hE: return 4'h4; default: return 4'h6;
    endcase
  endfunction

  function automatic logic [63:0] sb0_ref(input logic [63:0] p);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb0(p[4*i +: 4]);
    return r;
  endfunction

  // One register stage; output shares re-masked with the first 8 random bits.
  always @(posedge clk) begin
    for (int k = 0; k < NSBOX; k++) begin
      sb_out1[4*k +: 4] <= sb0(sb_in1[4*k +: 4] ^ sb_in2[4*k +: 4] ^ sb_in3[4*k +: 4])
                           ^ sb_r[96*k +: 4] ^ sb_r[96*k+4 +: 4];
      sb_out2[4*k +: 4] <= sb_r[96*k +: 4];
      sb_out3[4*k +: 4] <= sb_r[96*k+4 +: 4];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- drivers ----------------
  task automatic new_word();
    for (int i = 0; i < RW / 32; i++) rnd[32*i +: 32] = $urandom();
    rnd[31:0] = word_ctr;
    word_ctr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation: stall = rnd_valid-low cycles before batch 2,
  // bp = cycles out_ready is held low in DONE while a new in_valid is pending.
  task automatic run_op(input logic [63:0] plain, input logic [63:0] exp,
                        input int stall, input int bp);
    logic [63:0]   s1, s2, s3, h1, h2, h3;
    logic [RW-1:0] last_r;
    int            cyc, used, left;
    logic          consume, ok_r, ok_bp;
    s2 = {$urandom(), $urandom()};
    s3 = {$urandom(), $urandom()};
    s1 = plain ^ s2 ^ s3;
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    in_s1 = s1; in_s2 = s2; in_s3 = s3;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    cyc = 0; used = 0; left = stall; ok_r = 1'b1; last_r = '0;
    new_word();
    while (!out_valid && cyc < 60) begin
      rnd_valid = !(used == 2 && left > 0);
      if (!rnd_valid) begin
        left--;
        if (sb_r !== last_r) ok_r = 1'b0;
      end
      consume = rnd_valid && rnd_ready;
      tick();
      cyc++;
      if (consume) begin
        used++;
        if (sb_r !== rnd) ok_r = 1'b0;
        last_r = rnd;
        if (used == 1) begin
          check("sb_in1_batch0", {48'd0, sb_in1}, {48'd0, s1[15:0]});
          check("nb_nibble0", {56'd0, sb_nb[7:0]}, {56'd0, s2[7:4], s1[7:4]});
        end
        if (used == 4) check("nb_wrap15", {56'd0, sb_nb[31:24]}, {56'd0, s2[3:0], s1[3:0]});
        new_word();
      end
    end
    rnd_valid = 1'b1;
    check("latency", 64'(cyc), 64'(7 + stall));
    check("rnd_words", 64'(used), 64'd4);
    check("rnd_fresh_held", {63'd0, ok_r}, 64'd1);
    check("result", out_s1 ^ out_s2 ^ out_s3, exp_q.pop_front());
    h1 = out_s1; h2 = out_s2; h3 = out_s3;
    ok_bp = 1'b1;
    if (bp > 0) begin
      in_s1 = 64'h1111; in_s2 = 64'h2222; in_s3 = 64'h3333;
      in_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
        tick();
        if (out_s1 !== h1 || out_s2 !== h2 || out_s3 !== h3 || in_ready || !out_valid)
          ok_bp = 1'b0;
      end
      check("bp_hold", {63'd0, ok_bp}, 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handshake_idle", {62'd0, busy, out_valid}, 64'd0);
    if (bp > 0) begin
      check("no_early_accept", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] p;
    rst_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b1;
    in_s1 = '0; in_s2 = '0; in_s3 = '0; rnd = '0;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    check("rst_flags", {60'd0, in_ready, out_valid, rnd_ready, busy}, {60'd0, 4'b1000});
    check("rst_sb_in", {16'd0, sb_in1, sb_in2, sb_in3}, 64'd0);
    check("rst_sb_nb_r", {63'd0, |{sb_nb, sb_r}}, 64'd0);

    // Plain vector with zero masks, then masked directed vectors.
    in_s1 = 64'h0123456789ABCDEF; in_s2 = '0; in_s3 = '0;
    run_op(64'h0123456789ABCDEF, 64'hCAD3EBF789150246, 0, 0);
    run_op(64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC, 0, 0);
    run_op(64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666, 0, 0);
    run_op(64'hFEDCBA9876543210, 64'h642051987FBE3DAC, 0, 0);
    run_op(64'h0123456789ABCDEF, 64'hCAD3EBF789150246, 3, 0);
    run_op(64'hFEDCBA9876543210, 64'h642051987FBE3DAC, 0, 5);

    // Reset during batch 1 aborts the operation.
    in_s1 = 64'hDEADBEEFCAFEF00D; in_s2 = 64'h0F0F0F0F0F0F0F0F; in_s3 = '0;
    in_valid = 1'b1; new_word();
    tick();
    in_valid = 1'b0;
    tick(); new_word();
    tick();
    rst_i = 1'b0;
    #1;
    check("abort_flags", {62'd0, out_valid, busy}, 64'd0);
    check("abort_sb_in", {16'd0, sb_in1, sb_in2, sb_in3}, 64'd0);
    check("abort_sb_nb_r", {63'd0, |{sb_nb, sb_r}}, 64'd0);
    tick();
    rst_i = 1'b1;
    tick();
    run_op(64'h0123456789ABCDEF, 64'hCAD3EBF789150246, 0, 0);

    for (int n = 0; n < 8; n++) begin
      p = {$urandom(), $urandom()};
      run_op(p, sb0_ref(p), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
